// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 32-bit words into instruction memory
module prog_loader #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] a,
    output logic [31:0]       d,
    output logic              we,
    output logic              exec,
    output logic [ADDR_W:0]   words,
    output logic              err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic [1:0]        idx_q;
    logic              last_q;
    logic              ready_q;
    logic              we_q;
    logic              exec_q;
    logic              err_q;
    logic [ADDR_W-1:0] a_q;
    logic [31:0]       d_q;
    logic [ADDR_W:0]   words_q;

    // Big-endian placement: byte index 0 lands in the most significant byte.
    always_comb begin
        asm_d = asm_q;
        case (idx_q)
            2'd0:    asm_d[31:24] = in_data;
            2'd1:    asm_d[23:16] = in_data;
            2'd2:    asm_d[15:8]  = in_data;
            default: asm_d[7:0]   = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            asm_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            exec_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
            words_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (words_q == DEPTH_W) begin
                            state_q <= ERR;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (idx_q == 2'd3 || in_last) begin
                            // Unfilled low bytes of a short final word are still zero in asm_q.
                            state_q <= WRITE;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            a_q     <= words_q[ADDR_W-1:0];
                            d_q     <= asm_d;
                            last_q  <= in_last;
                        end else begin
                            asm_q <= asm_d;
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    words_q <= words_q + 1'b1;
                    asm_q   <= '0;
                    idx_q   <= '0;
                    if (last_q) begin
                        state_q <= RUN;
                        exec_q  <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= ERR;
                end
            endcase
        end
    end

    // Reset gates ready directly so no byte is taken while rst is held.
    assign in_ready = ready_q & ~rst;
    assign a        = a_q;
    assign d        = d_q;
    assign we       = we_q;
    assign exec     = exec_q;
    assign words    = words_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;

    logic        in_ready1, we1, exec1, err1;
    logic [8:0]  a1;
    logic [31:0] d1;
    logic [9:0]  words1;

    logic        in_ready2, we2, exec2, err2;
    logic [1:0]  a2;
    logic [31:0] d2;
    logic [2:0]  words2;

    logic        sel = 1'b0;
    logic        cur_ready, cur_we, cur_exec, cur_err;
    logic [31:0] cur_a, cur_d, cur_words;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit bad_excl = 1'b0;
    int base;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(9), .DEPTH(512)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready1), .a(a1), .d(d1), .we(we1), .exec(exec1), .words(words1), .err(err1)
    );

    prog_loader #(.ADDR_W(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready2), .a(a2), .d(d2), .we(we2), .exec(exec2), .words(words2), .err(err2)
    );

    always_comb begin
        cur_ready = sel ? in_ready2 : in_ready1;
        cur_we    = sel ? we2 : we1;
        cur_exec  = sel ? exec2 : exec1;
        cur_err   = sel ? err2 : err1;
        cur_a     = sel ? {30'b0, a2} : {23'b0, a1};
        cur_d     = sel ? d2 : d1;
        cur_words = sel ? {29'b0, words2} : {22'b0, words1};
    end

    always @(posedge clk) if (cur_we) wr_cnt <= wr_cnt + 1;
    always @(negedge clk) if ((we1 && exec1) || (we2 && exec2)) bad_excl <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, cur_ready}, 32'd0);
        chk("rst_outs", {cur_we, cur_exec, cur_err}, 32'd0);
        chk("rst_words", cur_words, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, cur_ready}, 32'd1);
    endtask

    // Sends nb bytes of w (MSB first); returns on the cycle after the final byte is accepted.
    task automatic send_word(input logic [31:0] w, input int nb, input bit last, input bit gap);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < nb; i++) begin
            int n;
            n = 0;
            while (!cur_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b1;
            in_data  = tmp[31:24];
            tmp      = tmp << 8;
            in_last  = last && (i == nb - 1);
            @(negedge clk);
            if (gap && i < nb - 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                chk("gap_ready", {31'b0, cur_ready}, 32'd1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // single word, last on 4th byte
        do_reset();
        base = wr_cnt;
        send_word(32'h21CE0029, 4, 1'b1, 1'b0);
        chk("w1_we", {31'b0, cur_we}, 32'd1);
        chk("w1_a", cur_a, 32'd0);
        chk("w1_d", cur_d, 32'h21CE0029);
        chk("w1_ready", {31'b0, cur_ready}, 32'd0);
        chk("w1_exec_lo", {31'b0, cur_exec}, 32'd0);
        @(negedge clk);
        chk("w1_exec", {31'b0, cur_exec}, 32'd1);
        chk("w1_we_lo", {31'b0, cur_we}, 32'd0);
        chk("w1_words", cur_words, 32'd1);
        repeat (3) @(negedge clk);
        chk("w1_one_write", wr_cnt - base, 32'd1);
        chk("run_hold_d", cur_d, 32'h21CE0029);
        chk("run_ready", {31'b0, cur_ready}, 32'd0);

        // two words
        do_reset();
        send_word(32'h20080005, 4, 1'b0, 1'b0);
        chk("w2a_we", {31'b0, cur_we}, 32'd1);
        chk("w2a_a", cur_a, 32'd0);
        chk("w2a_d", cur_d, 32'h20080005);
        send_word(32'hADC80000, 4, 1'b1, 1'b0);
        chk("w2b_we", {31'b0, cur_we}, 32'd1);
        chk("w2b_a", cur_a, 32'd1);
        chk("w2b_d", cur_d, 32'hADC80000);
        @(negedge clk);
        chk("w2_exec", {31'b0, cur_exec}, 32'd1);
        chk("w2_words", cur_words, 32'd2);

        // partial word
        do_reset();
        send_word(32'h2008FFFF, 2, 1'b1, 1'b0);
        chk("part_we", {31'b0, cur_we}, 32'd1);
        chk("part_a", cur_a, 32'd0);
        chk("part_d", cur_d, 32'h20080000);
        @(negedge clk);
        chk("part_exec", {31'b0, cur_exec}, 32'd1);

        // toggling valid
        do_reset();
        send_word(32'h21CE0029, 4, 1'b1, 1'b1);
        chk("gap_we", {31'b0, cur_we}, 32'd1);
        chk("gap_d", cur_d, 32'h21CE0029);
        chk("gap_wr_ready", {31'b0, cur_ready}, 32'd0);

        // reset mid-word discards partial bytes
        do_reset();
        send_word(32'h11223344, 4, 1'b0, 1'b0);
        send_word(32'h55667788, 3, 1'b0, 1'b0);
        base = wr_cnt;
        do_reset();
        chk("abort_no_we", wr_cnt - base, 32'd0);
        send_word(32'hCAFEBABE, 4, 1'b1, 1'b0);
        chk("fresh_a", cur_a, 32'd0);
        chk("fresh_d", cur_d, 32'hCAFEBABE);
        @(negedge clk);
        chk("fresh_words", cur_words, 32'd1);

        // overflow on DEPTH=4 instance
        sel = 1'b1;
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h01020300 + i, 4, 1'b0, 1'b0);
            chk("ovf_a", cur_a, i);
            chk("ovf_d", cur_d, 32'h01020300 + i);
        end
        @(negedge clk);
        chk("ovf_words", cur_words, 32'd4);
        send_word(32'hEE000000, 1, 1'b0, 1'b0);
        chk("ovf_err", {31'b0, cur_err}, 32'd1);
        chk("ovf_we", {31'b0, cur_we}, 32'd0);
        chk("ovf_exec", {31'b0, cur_exec}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ovf_writes", wr_cnt - base, 32'd4);
        chk("ovf_hold_a", cur_a, 32'd3);
        chk("ovf_ready", {31'b0, cur_ready}, 32'd0);
        do_reset();
        chk("ovf_err_clr", {31'b0, cur_err}, 32'd0);

        chk("we_exec_excl", {31'b0, bad_excl}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
